// File: rtl/flag_cross_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flag_cross_scheduler
// Purpose  : Receive-side scheduler for toggle-encoded event flags entering
//            the clkB domain. Each channel's toggle is synchronized, edge
//            detected and latched as pending; pending events are offered one
//            at a time to a single consumer using round-robin arbitration.
//            Each consumed event is acknowledged by flipping that channel's
//            ack toggle.
// Ports    : clkB          - clock for every flop in the block
//            rstB_n        - async-assert, active-low reset
//            req_tgl_clkA  - [N_CH] per-channel event toggles (asynchronous)
//            evt_valid     - event offered to the consumer
//            evt_ch        - [CH_W] channel of the offered event
//            evt_ready     - consumer accepts (handshake on valid & ready)
//            ack_tgl_clkB  - [N_CH] toggles once per consumed event
//            pending_clkB  - [N_CH] per-channel pending bits
//            overrun_clkB  - [N_CH] sticky protocol-violation flags
// Revision : 1.0 - initial release
// ============================================================================
module flag_cross_scheduler #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = $clog2(N_CH)
) (
  input  logic            clkB,
  input  logic            rstB_n,
  input  logic [N_CH-1:0] req_tgl_clkA,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  input  logic            evt_ready,
  output logic [N_CH-1:0] ack_tgl_clkB,
  output logic [N_CH-1:0] pending_clkB,
  output logic [N_CH-1:0] overrun_clkB
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  // Synchronizer chain: index 0 samples the asynchronous input.
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  hist_q;
  logic [N_CH-1:0]                  pending_q, pending_d;
  logic [N_CH-1:0]                  overrun_q, overrun_d;
  logic [N_CH-1:0]                  ack_q;
  logic [N_CH-1:0]                  evt_edge;
  logic [N_CH-1:0]                  hs_vec;
  logic                             hs;
  state_t                           state_q;
  logic                             evt_valid_q;
  logic [CH_W-1:0]                  evt_ch_q;
  logic [CH_W-1:0]                  last_grant_q;
  logic [CH_W-1:0]                  cand;
  logic [CH_W-1:0]                  next_ch;
  logic                             found;

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl_clkA};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign hs       = evt_valid_q & evt_ready;

  always_comb begin
    hs_vec = '0;
    if (hs) hs_vec[evt_ch_q] = 1'b1;
  end

  // A fresh edge re-sets pending even when the same channel is being
  // consumed this cycle, so a toggle arriving right at the ack is kept.
  assign pending_d = (pending_q & ~hs_vec) | evt_edge;
  assign overrun_d = overrun_q | (evt_edge & pending_q & ~hs_vec);

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    cand    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_grant_q) + k) % N_CH);
      if (!found && pending_q[cand]) begin
        found   = 1'b1;
        next_ch = cand;
      end
    end
  end

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      state_q      <= S_IDLE;
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      ack_q        <= '0;
      last_grant_q <= CH_W'(N_CH - 1);
      pending_q    <= '0;
      overrun_q    <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            evt_ch_q    <= next_ch;
            evt_valid_q <= 1'b1;
            state_q     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            ack_q[evt_ch_q] <= ~ack_q[evt_ch_q];
            last_grant_q    <= evt_ch_q;
            evt_valid_q     <= 1'b0;
            state_q         <= S_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_ch       = evt_ch_q;
  assign ack_tgl_clkB = ack_q;
  assign pending_clkB = pending_q;
  assign overrun_clkB = overrun_q;

endmodule
`default_nettype wire

// File: doc/flag_cross_scheduler.md
# flag_cross_scheduler

Receive-side scheduler for event flags crossing into the clkB domain. Each of N_CH source channels signals an event by toggling a level. The block synchronizes each toggle with a multi-stage flop chain and records it as pending. It then hands pending events one at a time to a single shared clkB consumer over a valid/ready handshake, using round-robin arbitration. Completion is returned per channel as an acknowledge toggle, which the source side synchronizes back to close the loop.

## Interface
- N_CH, 4: number of source channels, 2..16.
- SYNC_STAGES, 2: synchronizer flops per channel, ≥2.
- CH_W, $clog2(N_CH): channel index width (derived).

Ports:
- clkB  in  1  single clock; every flop in the block is clocked by it.
- rstB_n  in  1  reset, asynchronous assert and active-low; deassertion is synchronized externally.
- req_tgl_clkA  in  N_CH  per-channel event toggles from the foreign domain; treated as asynchronous.
- evt_valid  out  1  an event is offered to the consumer.
- evt_ch  out  CH_W  channel of the offered event.
- evt_ready  in  1  consumer accepts; the handshake completes on a clkB edge where evt_valid & evt_ready.
- ack_tgl_clkB  out  N_CH  toggles once per consumed event of that channel.
- pending_clkB  out  N_CH  per-channel pending bits.
- overrun_clkB  out  N_CH  sticky protocol-violation flags.

## Operation
- Per channel i, a SYNC_STAGES-deep chain samples req_tgl_clkA[i]. A history flop holds the previous chain output.
- edge[i] is defined as chain output != history. The history flop updates every cycle.
- Pending update per channel:
  - edge[i] sets pending[i].
  - The handshake on channel i clears pending[i].
  - If both happen in the same cycle, set wins and no overrun is flagged.
- Protocol: a source must not toggle again until it has seen its ack toggle.
  - If edge[i] occurs while pending[i]=1 and channel i is not being handshaken that cycle, overrun[i] sets.
  - overrun[i] stays set until reset.
  - pending[i] is unchanged and the extra event is lost.
- Arbiter FSM, two states:
  - IDLE:
    - evt_valid=0.
    - If any pending bit is set, select the first set bit searching upward from last_grant+1, wrapping at N_CH.
    - Register the selection into evt_ch, assert evt_valid, go to OFFER.
  - OFFER:
    - evt_valid=1; evt_ch holds stable.
    - New pending bits do not alter evt_ch.
    - On handshake: clear pending[evt_ch], invert ack_tgl[evt_ch], set last_grant=evt_ch, go to IDLE.
- Throughput is at most one event per 2 cycles.

## Timing
- Reset values:
  - All outputs 0.
  - Sync chains and history flops 0; sources must also reset their toggles to 0.
  - FSM in IDLE.
  - last_grant = N_CH-1, so channel 0 has first priority.
- Reset asserted mid-OFFER:
  - evt_valid drops immediately, asynchronously.
  - All pending events are discarded and no ack is issued.
- Latency, counting edge 1 as the first clkB edge after req_tgl changes (meeting setup):
  - The chain output reflects the change after edge SYNC_STAGES.
  - pending is set after edge SYNC_STAGES+1.
  - evt_valid is high after edge SYNC_STAGES+2 if the FSM was IDLE with nothing else pending.
- Handshake to outputs:
  - ack_tgl and the pending clear are visible after the handshake edge.
  - evt_valid is low for exactly one cycle.
  - The next offer is visible one edge later.
- evt_valid must never deassert without a handshake, except on reset.

## Test plan
- Reset: drive rstB_n=0 with random inputs -> evt_valid, evt_ch, ack_tgl, pending, overrun all 0.
- Single event: SYNC_STAGES=2, toggle req[2] 0->1, evt_ready=1 -> pending[2] high after edge 3; evt_valid=1 with evt_ch=2 after edge 4; ack_tgl[2]=1 and pending[2]=0 after edge 5.
- Concurrent: toggle all four channels in one cycle, evt_ready held 1 -> grants issued in order 0,1,2,3, spaced 2 cycles apart; each ack_tgl bit toggles exactly once.
- Backpressure: hold evt_ready=0 for 10 cycles during an offer of ch1, and toggle ch3 meanwhile -> evt_valid stays 1 and evt_ch stays 1; ch3 is granted immediately after ch1 completes.
- Fairness and overrun:
  - ch0 re-toggles immediately on each ack while ch3 is pending -> ch3 is granted before ch0's second event.
  - ch0 toggled twice before its ack -> overrun[0]=1 and only one ch0 event is delivered.
- Reset mid-offer: assert rstB_n while evt_valid=1 -> evt_valid goes to 0 without waiting for clkB, and no ack toggle occurs.
